// File: rtl/ahb_flash_rd_arbiter.sv
// Two-port (instruction / data) read arbiter in front of the flash controller's AHB-Lite slave port.
// Optional build macro FLASH_ARB_FIXED_PRIO_EN: D port wins every tie instead of round-robin.
module ahb_flash_rd_arbiter #(
    parameter int AW = 24
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic [31:0]   HADDR,
    output logic [1:0]    HTRANS,
    output logic [2:0]    HSIZE,
    output logic          HWRITE,
    output logic          HSEL,
    input  logic          HREADY,
    input  logic [31:0]   HRDATA,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic [AW-3:0]   addr_q, addr_d;
    logic            i_rvalid_q, i_rvalid_d;
    logic            d_rvalid_q, d_rvalid_d;
    logic [31:0]     i_rdata_q, i_rdata_d;
    logic [31:0]     d_rdata_q, d_rdata_d;
    logic            win_s;
    logic [AW-3:0]   win_addr_s;
    logic            unused_addr_bits_s;

`ifdef FLASH_ARB_FIXED_PRIO_EN
    // Fixed priority: D takes every tie.
    always_comb begin
        if (d_req) begin
            win_s = PORT_D;
        end else begin
            win_s = PORT_I;
        end
    end
`else
    logic rr_last_q, rr_last_d;

    // Round-robin: on a tie the port not granted last time wins.
    always_comb begin
        if (i_req && d_req) begin
            win_s = ~rr_last_q;
        end else if (d_req) begin
            win_s = PORT_D;
        end else begin
            win_s = PORT_I;
        end
    end

    // rr_last remembers the owner of the most recent address phase.
    always_comb begin
        rr_last_d = rr_last_q;
        if (state_q == ST_ADDR && HREADY) begin
            rr_last_d = owner_q;
        end else begin
            rr_last_d = rr_last_q;
        end
    end

    // Round-robin history register; D counts as last granted out of reset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rr_last_q <= PORT_D;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    assign win_addr_s         = (win_s == PORT_D) ? d_addr[AW-1:2] : i_addr[AW-1:2];
    assign unused_addr_bits_s = ^{i_addr[1:0], d_addr[1:0]};

    // Next-state, latching of owner/address and read-data capture.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    owner_d = win_s;
                    addr_d  = win_addr_s;
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    if (owner_q == PORT_D) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = HRDATA;
                    end else begin
                        i_rvalid_d = 1'b1;
                        i_rdata_d  = HRDATA;
                    end
                    // A pending request goes straight to ADDR, no idle cycle.
                    if (i_req || d_req) begin
                        owner_d = win_s;
                        addr_d  = win_addr_s;
                        state_d = ST_ADDR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, transfer context and per-port response registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            owner_q    <= PORT_I;
            addr_q     <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= 32'h0000_0000;
            d_rdata_q  <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign i_gnt    = (state_q == ST_ADDR) && HREADY && (owner_q == PORT_I);
    assign d_gnt    = (state_q == ST_ADDR) && HREADY && (owner_q == PORT_D);
    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign HADDR    = {{(32-AW){1'b0}}, addr_q, 2'b00};
    assign HTRANS   = (state_q == ST_ADDR) ? 2'b10 : 2'b00;
    assign HSEL     = (state_q == ST_ADDR);
    assign HSIZE    = 3'b010;
    assign HWRITE   = 1'b0;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ahb_flash_rd_arbiter.sv
// Scoreboard bench for ahb_flash_rd_arbiter: per-port expected-data queues filled by the requesters,
// drained by a monitor on rvalid; grants logged for arbitration-order checks.
module tb_ahb_flash_rd_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0;
    logic [23:0] i_addr = 24'h0, d_addr = 24'h0;
    logic        i_gnt, d_gnt, i_rvalid, d_rvalid;
    logic [31:0] i_rdata, d_rdata;
    logic [31:0] HADDR, HRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE, HSEL, busy;
    logic        HREADY = 1'b1;
    logic [31:0] dph_addr = 32'h0;

    bit          rand_ready = 1'b0;
    bit          fixed_ready = 1'b1;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] i_exp_q[$], d_exp_q[$], i_ha_q[$], d_ha_q[$];
    bit          gnt_port[$];
    int          gnt_cyc[$];

    ahb_flash_rd_arbiter #(.AW(24)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HSEL(HSEL),
        .HREADY(HREADY), .HRDATA(HRDATA), .busy(busy)
    );

    always #5 HCLK = ~HCLK;

    // Flash contents: the four preloaded words, everything else a recognisable pattern.
    function automatic logic [31:0] mem_word(input logic [23:0] a);
        case (a[7:2])
            6'd0:    return 32'haaaaaa00;
            6'd1:    return 32'hbbbbbb01;
            6'd3:    return 32'hdddddd03;
            6'd5:    return 32'hffffff05;
            default: return {8'h5a, 16'h0000, a[7:2], 2'b00};
        endcase
    endfunction

    assign HRDATA = mem_word(dph_addr[23:0]);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Slave address-phase capture and cycle counter.
    initial forever begin
        @(posedge HCLK);
        cyc++;
        if (HSEL && HTRANS == 2'b10 && HREADY) dph_addr <= HADDR;
    end

    // HREADY driver: random wait states or a fixed level.
    initial forever begin
        @(posedge HCLK);
        #1;
        HREADY = rand_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
    end

    // Monitor: checks address on each grant and data on each rvalid against the scoreboard.
    initial forever begin
        @(negedge HCLK);
        if (HRESETn) begin
            if (i_gnt && d_gnt) chk("dual_gnt", 32'd1, 32'd0);
            if (i_gnt || d_gnt) begin
                chk("gnt_htrans", {30'h0, HTRANS}, 32'h2);
                gnt_port.push_back(d_gnt);
                gnt_cyc.push_back(cyc);
            end
            if (i_gnt) begin
                if (i_ha_q.size() == 0) chk("i_gnt_unexpected", 32'd1, 32'd0);
                else chk("i_haddr", HADDR, i_ha_q.pop_front());
            end
            if (d_gnt) begin
                if (d_ha_q.size() == 0) chk("d_gnt_unexpected", 32'd1, 32'd0);
                else chk("d_haddr", HADDR, d_ha_q.pop_front());
            end
            if (i_rvalid) begin
                if (i_exp_q.size() == 0) chk("i_rvalid_unexpected", 32'd1, 32'd0);
                else chk("i_rdata", i_rdata, i_exp_q.pop_front());
            end
            if (d_rvalid) begin
                if (d_exp_q.size() == 0) chk("d_rvalid_unexpected", 32'd1, 32'd0);
                else chk("d_rdata", d_rdata, d_exp_q.pop_front());
            end
        end
    end

    // One read on a port: raise req, wait (bounded) for gnt, drop req after the accepting edge.
    task automatic drive(input bit port, input logic [23:0] a, input bit expect_data);
        int n = 0;
        logic g;
        if (port) begin
            d_addr = a; d_req = 1'b1;
            if (expect_data) d_exp_q.push_back(mem_word(a));
            d_ha_q.push_back({8'h00, a[23:2], 2'b00});
        end else begin
            i_addr = a; i_req = 1'b1;
            if (expect_data) i_exp_q.push_back(mem_word(a));
            i_ha_q.push_back({8'h00, a[23:2], 2'b00});
        end
        do begin
            @(negedge HCLK);
            n++;
            g = port ? d_gnt : i_gnt;
        end while (!g && n < 1000);
        if (!g) chk(port ? "d_gnt_timeout" : "i_gnt_timeout", 32'd0, 32'd1);
        @(posedge HCLK);
        #1;
        if (port) d_req = 1'b0; else i_req = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((i_exp_q.size() != 0 || d_exp_q.size() != 0) && n < 3000) begin
            @(negedge HCLK);
            n++;
        end
        chk("drain", i_exp_q.size() + d_exp_q.size(), 32'd0);
        @(negedge HCLK);
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        HRESETn = 1'b0;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #2;
    endtask

    initial begin
        bit exp3[4];
        bit first2;
`ifdef FLASH_ARB_FIXED_PRIO_EN
        exp3   = '{1'b1, 1'b1, 1'b1, 1'b1};
        first2 = 1'b1;
`else
        exp3   = '{1'b0, 1'b1, 1'b0, 1'b1};
        first2 = 1'b0;
`endif
        // Reset values.
        repeat (2) @(negedge HCLK);
        chk("rst_htrans", {30'h0, HTRANS}, 32'h0);
        chk("rst_hsel", {31'h0, HSEL}, 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_gnt_rvalid", {28'h0, i_gnt, d_gnt, i_rvalid, d_rvalid}, 32'h0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("hsize_hwrite", {28'h0, HSIZE, HWRITE}, 32'h4);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #2;

        // 1: lone I read.
        drive(1'b0, 24'h000000, 1'b1);
        wait_drain();
        chk("t1_htrans_idle", {30'h0, HTRANS}, 32'h0);
        chk("t1_busy", {31'h0, busy}, 32'h0);
        chk("t1_d_rdata_untouched", d_rdata, 32'h0);

        // 2: simultaneous I/D after reset, back-to-back with no idle cycle.
        do_reset();
        gnt_port.delete(); gnt_cyc.delete();
        fork
            drive(1'b0, 24'h000004, 1'b1);
            drive(1'b1, 24'h00000C, 1'b1);
        join
        wait_drain();
        chk("t2_ngnt", gnt_port.size(), 32'd2);
        if (gnt_port.size() == 2) begin
            chk("t2_first", {31'h0, gnt_port[0]}, {31'h0, first2});
            chk("t2_gap", gnt_cyc[1] - gnt_cyc[0], 32'd2);
        end
        chk("t2_i_rdata", i_rdata, 32'hbbbbbb01);
        chk("t2_d_rdata", d_rdata, 32'hdddddd03);

        // 3: both ports hold req for four transfers each.
        gnt_port.delete(); gnt_cyc.delete();
        fork
            for (int k = 0; k < 4; k++) drive(1'b0, 24'h000000, 1'b1);
            for (int k = 0; k < 4; k++) drive(1'b1, 24'h000014, 1'b1);
        join
        wait_drain();
        chk("t3_ngnt", gnt_port.size(), 32'd8);
        if (gnt_port.size() == 8)
            for (int k = 0; k < 4; k++) chk($sformatf("t3_order%0d", k), {31'h0, gnt_port[k]}, {31'h0, exp3[k]});

        // 4: unaligned D read.
        drive(1'b1, 24'h000016, 1'b1);
        wait_drain();
        chk("t4_d_rdata", d_rdata, 32'hffffff05);

        // 5: reset while in DATA with the slave stalled.
        d_addr = 24'h00000C; d_req = 1'b1;
        d_ha_q.push_back(32'h0000000C);
        begin
            int n = 0;
            do begin @(negedge HCLK); n++; end while (!d_gnt && n < 100);
            chk("t5_gnt", {31'h0, d_gnt}, 32'h1);
        end
        fixed_ready = 1'b0;
        @(posedge HCLK);
        #1;
        d_req = 1'b0;
        @(negedge HCLK);
        chk("t5_busy_data", {31'h0, busy}, 32'h1);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("t5_htrans_rst", {30'h0, HTRANS}, 32'h0);
        chk("t5_busy_rst", {31'h0, busy}, 32'h0);
        repeat (3) @(negedge HCLK);
        chk("t5_no_rvalid", {30'h0, i_rvalid, d_rvalid}, 32'h0);
        HRESETn = 1'b1;
        fixed_ready = 1'b1;
        repeat (4) @(negedge HCLK);
        @(posedge HCLK);
        #2;
        drive(1'b0, 24'h000000, 1'b1);
        wait_drain();
        chk("t5_i_rdata", i_rdata, 32'haaaaaa00);

        // 6: 20-cycle HREADY stall in ADDR.
        @(negedge HCLK);
        fixed_ready = 1'b0;
        @(posedge HCLK);
        #2;
        fork
            drive(1'b0, 24'h000014, 1'b1);
            begin
                @(posedge HCLK);
                for (int k = 0; k < 20; k++) begin
                    @(negedge HCLK);
                    chk("t6_haddr", HADDR, 32'h00000014);
                    chk("t6_htrans", {30'h0, HTRANS}, 32'h2);
                    chk("t6_no_gnt", {31'h0, i_gnt}, 32'h0);
                end
                fixed_ready = 1'b1;
            end
        join
        wait_drain();
        chk("t6_i_rdata", i_rdata, 32'hffffff05);

        // Random traffic with random wait states on both ports.
        rand_ready = 1'b1;
        fork
            for (int k = 0; k < 30; k++) begin
                drive(1'b0, 24'($urandom), 1'b1);
                repeat ($urandom_range(0, 3)) @(posedge HCLK);
                #1;
            end
            for (int k = 0; k < 30; k++) begin
                drive(1'b1, 24'($urandom), 1'b1);
                repeat ($urandom_range(0, 3)) @(posedge HCLK);
                #1;
            end
        join
        wait_drain();
        rand_ready = 1'b0;
        repeat (3) @(negedge HCLK);
        chk("end_idle", {31'h0, busy}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
